// File: rtl/pic_core_n.sv
// pic_core_n: clocked, parametrised 8259-style programmable interrupt controller.
//
// Captures N_IRQ request lines (edge or level), arbitrates them with fully-nested
// or rotating priority, raises a registered interrupt to the CPU and answers the
// two-pulse INTA handshake with a vector byte. Supports auto-EOI and master/slave
// cascading over a CAS bus.
//
// Ports:
//   i_clk         system clock, all state on rising edge
//   i_rst         asynchronous, active-high reset
//   i_wr          register write strobe (one cycle)
//   i_rd          register read enable
//   i_addr        register select
//   i_wdata       register write data
//   o_rdata       combinational read data (0 when i_rd=0)
//   i_ir          interrupt requests, synchronous to i_clk
//   o_int         interrupt to CPU (registered)
//   i_inta        interrupt acknowledge, active low
//   i_sp          1 = master, 0 = slave
//   i_cas_in      cascade ID from the master (slave mode)
//   o_cas_out     cascade ID driven by the master
//   o_cas_out_en  o_cas_out valid
//   o_dout        vector byte
//   o_dout_en     o_dout valid
//
// Acknowledge FSM:
//   state    | meaning
//   S_IDLE   | waiting for the first INTA falling edge; latches the winner
//   S_PULSE1 | first INTA pulse low, waiting for INTA to return high
//   S_WAIT2  | between pulses, waiting for the second INTA falling edge
//   S_PULSE2 | vector on the bus, waiting for INTA to return high

module pic_core_n #(
    parameter int N_IRQ = 8,
    parameter int CAS_W = 3,
    parameter int IDX_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic             i_rd,
    input  logic [2:0]       i_addr,
    input  logic [7:0]       i_wdata,
    output logic [7:0]       o_rdata,
    input  logic [N_IRQ-1:0] i_ir,
    output logic             o_int,
    input  logic             i_inta,
    input  logic             i_sp,
    input  logic [CAS_W-1:0] i_cas_in,
    output logic [CAS_W-1:0] o_cas_out,
    output logic             o_cas_out_en,
    output logic [7:0]       o_dout,
    output logic             o_dout_en
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PULSE1 = 2'd1,
        S_WAIT2  = 2'd2,
        S_PULSE2 = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_IRQ - 1);

    // Highest-priority set bit of vec: priority starts at plow+1 and descends
    // cyclically. Returns {found, index}. The loop runs from lowest to highest
    // priority so the last hit is the winner.
    function automatic logic [IDX_W:0] f_top(input logic [N_IRQ-1:0] vec,
                                             input logic [IDX_W-1:0] plow);
        logic [IDX_W:0] res;
        int lvl;
        res = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            lvl = int'(plow) + 1 + i;
            if (lvl >= N_IRQ) lvl = lvl - N_IRQ;
            if (vec[IDX_W'(lvl)]) res = {1'b1, IDX_W'(lvl)};
        end
        return res;
    endfunction

    // Rank of level k under the current rotation; 0 is the highest priority.
    function automatic int f_rank(input logic [IDX_W-1:0] k,
                                  input logic [IDX_W-1:0] plow);
        int r;
        r = int'(k) + N_IRQ - int'(plow) - 1;
        if (r >= N_IRQ) r = r - N_IRQ;
        return r;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;

    logic [N_IRQ-1:0] r_imr;
    logic [N_IRQ-1:0] r_irr;
    logic [N_IRQ-1:0] r_isr;
    logic [N_IRQ-1:0] r_slave_map;
    logic [N_IRQ-1:0] r_ir_d;
    logic             r_ltim;
    logic             r_aeoi;
    logic             r_rot;
    logic [7:0]       r_vbase;
    logic [CAS_W-1:0] r_slave_id;
    logic [IDX_W-1:0] r_prio_low;
    logic [IDX_W-1:0] r_win;
    logic             r_spur;
    logic             r_commit;
    logic             r_inta_d;
    logic             r_int;
    logic [7:0]       r_dout;
    logic             r_dout_en;
    logic [CAS_W-1:0] r_cas_out;
    logic             r_cas_out_en;

    logic             w_fe;
    logic             w_latch;
    logic             w_wait2;
    logic             w_end;
    logic [N_IRQ-1:0] w_pend;
    logic [IDX_W:0]   w_pend_top;
    logic [IDX_W:0]   w_isr_top;
    logic [IDX_W:0]   w_eoi_top;
    logic             w_int_cond;
    logic             w_cas_match;
    logic             w_commit;
    logic [IDX_W-1:0] w_commit_idx;
    logic             w_drive_dout;
    logic             w_aeoi;
    logic             w_wr_eoi;
    logic [IDX_W-1:0] w_eoi_lvl;
    logic [N_IRQ-1:0] w_irr_nxt;
    logic [N_IRQ-1:0] w_isr_nxt;
    logic [IDX_W-1:0] w_prio_nxt;

    assign w_fe       = r_inta_d & ~i_inta;
    assign w_pend     = r_irr & ~r_imr;
    assign w_pend_top = f_top(w_pend, r_prio_low);
    assign w_isr_top  = f_top(r_isr, r_prio_low);

    // A pending request interrupts only if it outranks everything in service.
    assign w_int_cond = w_pend_top[IDX_W] &
                        (~w_isr_top[IDX_W] |
                         (f_rank(w_pend_top[IDX_W-1:0], r_prio_low) <
                          f_rank(w_isr_top[IDX_W-1:0], r_prio_low)));

    assign w_cas_match = (i_cas_in == r_slave_id);

    // Master commits at the first pulse using the live winner; a slave commits
    // at the second pulse using the winner latched at the first pulse.
    assign w_commit     = (w_latch & i_sp & w_pend_top[IDX_W]) |
                          (w_wait2 & ~i_sp & ~r_spur & w_cas_match);
    assign w_commit_idx = w_latch ? w_pend_top[IDX_W-1:0] : r_win;

    // A master leaves the vector to the slave when the level is cascaded;
    // a spurious cycle always gets the local vector.
    assign w_drive_dout = w_wait2 &
                          (i_sp ? (r_spur | ~r_slave_map[r_win]) : w_cas_match);

    assign w_aeoi    = w_end & r_aeoi & r_commit;
    assign w_wr_eoi  = i_wr & (i_addr == 3'd3);
    assign w_eoi_lvl = i_wdata[IDX_W-1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_wait2     = 1'b0;
        w_end       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fe) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_PULSE1;
                end
            end
            S_PULSE1: begin
                if (i_inta) w_state_nxt = S_WAIT2;
            end
            S_WAIT2: begin
                if (w_fe) begin
                    w_wait2     = 1'b1;
                    w_state_nxt = S_PULSE2;
                end
            end
            S_PULSE2: begin
                if (i_inta) begin
                    w_end       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Edge mode: a new edge wins over the acknowledge clear of the same bit.
    always_comb begin
        w_irr_nxt = r_irr;
        if (r_ltim) begin
            w_irr_nxt = i_ir;
        end else begin
            if (w_commit) w_irr_nxt[w_commit_idx] = 1'b0;
            w_irr_nxt = w_irr_nxt | (i_ir & ~r_ir_d);
        end
    end

    // In-service update: acknowledge commit / auto-EOI first, then any EOI
    // written in the same cycle acts on the result.
    always_comb begin
        w_isr_nxt  = r_isr;
        w_prio_nxt = r_prio_low;
        w_eoi_top  = '0;
        if (w_commit) w_isr_nxt[w_commit_idx] = 1'b1;
        if (w_aeoi) begin
            w_isr_nxt[r_win] = 1'b0;
            w_prio_nxt       = r_win;
        end
        if (w_wr_eoi) begin
            if (!i_wdata[7]) begin
                w_eoi_top = f_top(w_isr_nxt, w_prio_nxt);
                if (w_eoi_top[IDX_W]) begin
                    w_isr_nxt[w_eoi_top[IDX_W-1:0]] = 1'b0;
                    w_prio_nxt                      = w_eoi_top[IDX_W-1:0];
                end
            end else if ((int'(w_eoi_lvl) < N_IRQ) && w_isr_nxt[w_eoi_lvl]) begin
                w_isr_nxt[w_eoi_lvl] = 1'b0;
                w_prio_nxt           = w_eoi_lvl;
            end
        end
        if (!r_rot) w_prio_nxt = LAST;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_imr        <= '1;
            r_irr        <= '0;
            r_isr        <= '0;
            r_slave_map  <= '0;
            r_ir_d       <= '0;
            r_ltim       <= 1'b0;
            r_aeoi       <= 1'b0;
            r_rot        <= 1'b0;
            r_vbase      <= '0;
            r_slave_id   <= '0;
            r_prio_low   <= LAST;
            r_win        <= LAST;
            r_spur       <= 1'b0;
            r_commit     <= 1'b0;
            r_inta_d     <= 1'b1;
            r_int        <= 1'b0;
            r_dout       <= '0;
            r_dout_en    <= 1'b0;
            r_cas_out    <= '0;
            r_cas_out_en <= 1'b0;
        end else begin
            r_ir_d     <= i_ir;
            r_inta_d   <= i_inta;
            r_irr      <= w_irr_nxt;
            r_isr      <= w_isr_nxt;
            r_prio_low <= w_prio_nxt;
            r_int      <= w_latch ? 1'b0 : w_int_cond;

            if (i_wr) begin
                case (i_addr)
                    3'd0: r_imr <= i_wdata[N_IRQ-1:0];
                    3'd1: begin
                        r_ltim <= i_wdata[0];
                        r_aeoi <= i_wdata[1];
                        r_rot  <= i_wdata[2];
                    end
                    3'd2: r_vbase <= {i_wdata[7:IDX_W], {IDX_W{1'b0}}};
                    3'd4: r_slave_map <= i_wdata[N_IRQ-1:0];
                    3'd5: r_slave_id <= i_wdata[CAS_W-1:0];
                    default: ;
                endcase
            end

            if (w_latch) begin
                r_win    <= w_pend_top[IDX_W] ? w_pend_top[IDX_W-1:0] : LAST;
                r_spur   <= ~w_pend_top[IDX_W];
                r_commit <= w_commit;
                if (w_commit && r_slave_map[w_commit_idx]) begin
                    r_cas_out    <= CAS_W'(w_commit_idx);
                    r_cas_out_en <= 1'b1;
                end
            end

            if (w_wait2) begin
                if (w_commit) r_commit <= 1'b1;
                if (w_drive_dout) begin
                    r_dout    <= r_vbase | 8'(r_win);
                    r_dout_en <= 1'b1;
                end
            end

            if (w_end) begin
                r_dout_en    <= 1'b0;
                r_cas_out_en <= 1'b0;
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        if (i_rd) begin
            case (i_addr)
                3'd0:    o_rdata = 8'(r_imr);
                3'd1:    o_rdata = 8'(r_irr);
                3'd2:    o_rdata = 8'(r_isr);
                3'd3:    o_rdata = r_vbase;
                3'd4:    o_rdata = 8'(r_slave_map);
                3'd5:    o_rdata = 8'(r_slave_id);
                default: o_rdata = '0;
            endcase
        end
    end

    assign o_int        = r_int;
    assign o_dout       = r_dout;
    assign o_dout_en    = r_dout_en;
    assign o_cas_out    = r_cas_out;
    assign o_cas_out_en = r_cas_out_en;

endmodule

// File: tb/tb_pic_core_n.sv
module tb_pic_core_n;
    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst, wr, rd, inta, sp;
    logic [2:0] addr, cas_in, cas_out;
    logic [7:0] wdata, rdata, dout, ir;
    logic       irq, cas_en, dout_en;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pic_core_n #(.N_IRQ(8), .CAS_W(3), .IDX_W(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_rd(rd), .i_addr(addr),
        .i_wdata(wdata), .o_rdata(rdata), .i_ir(ir), .o_int(irq),
        .i_inta(inta), .i_sp(sp), .i_cas_in(cas_in), .o_cas_out(cas_out),
        .o_cas_out_en(cas_en), .o_dout(dout), .o_dout_en(dout_en)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model helpers: priority order is plow+1, plow+2, ... mod N.
    function automatic int m_top(input logic [7:0] v, input int plow);
        for (int r = 0; r < N; r++) begin
            int lvl;
            lvl = (plow + 1 + r) % N;
            if (v[lvl]) return lvl;
        end
        return -1;
    endfunction

    function automatic int m_rank(input int k, input int plow);
        return (k - plow - 1 + 2 * N) % N;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wreg(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk); wr = 1'b1; addr = a; wdata = d;
        @(negedge clk); wr = 1'b0;
    endtask

    task automatic rreg(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk); rd = 1'b1; addr = a;
        #1 d = rdata;
        rd = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr = 1'b0; rd = 1'b0; inta = 1'b1; sp = 1'b1;
        ir = '0; cas_in = '0; addr = '0; wdata = '0;
        cyc(2); rst = 1'b0; cyc(2);
    endtask

    // Full two-pulse acknowledge; samples enables during each INTA low and after.
    task automatic ack(output logic [7:0] a_dout, output logic a_den1, output logic a_den2,
                       output logic a_den3, output logic [2:0] a_cas, output logic a_cen1,
                       output logic a_cen2, output logic a_cen3);
        @(negedge clk); inta = 1'b0;
        @(negedge clk); a_den1 = dout_en; a_cen1 = cas_en; a_cas = cas_out;
        @(negedge clk); inta = 1'b1;
        @(negedge clk);
        @(negedge clk); inta = 1'b0;
        @(negedge clk); a_den2 = dout_en; a_dout = dout; a_cen2 = cas_en;
        @(negedge clk); inta = 1'b1;
        @(negedge clk); a_den3 = dout_en; a_cen3 = cas_en;
    endtask

    task automatic test_reset();
        logic [7:0] r;
        logic [7:0] exp_rd [8];
        exp_rd = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_reset();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_int: got %b want 0", irq); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h want 00", dout); end
        checks++; if (dout_en !== 1'b0) begin errors++; $display("FAIL rst_dout_en: got %b want 0", dout_en); end
        checks++; if ({cas_en, cas_out} !== 4'h0) begin errors++; $display("FAIL rst_cas: got %b/%h want 0/0", cas_en, cas_out); end
        addr = 3'd0; #1;
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata_idle: got %h want 00", rdata); end
        for (int a = 0; a < 8; a++) begin
            rreg(3'(a), r);
            checks++; if (r !== exp_rd[a]) begin errors++; $display("FAIL rst_reg%0d: got %h want %h", a, r, exp_rd[a]); end
        end
        checks++; if (dut.r_prio_low !== 3'd7) begin errors++; $display("FAIL rst_prio: got %0d want 7", dut.r_prio_low); end
    endtask

    task automatic test_master_edge();
        logic [7:0] d, r; logic e1, e2, e3, c1, c2, c3; logic [2:0] cs;
        do_reset();
        wreg(1, 8'h00); wreg(2, 8'h37); wreg(0, 8'h00);
        rreg(3, r);
        checks++; if (r !== 8'h30) begin errors++; $display("FAIL me_vbase: got %h want 30", r); end
        ir = 8'h12; cyc(3);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL me_int_rise: got %b want 1", irq); end
        ack(d, e1, e2, e3, cs, c1, c2, c3);
        checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL me_den_p1: got %b want 0", e1); end
        checks++; if ({e2, d} !== 9'h131) begin errors++; $display("FAIL me_vec1: got %b/%h want 1/31", e2, d); end
        checks++; if (e3 !== 1'b0) begin errors++; $display("FAIL me_den_after: got %b want 0", e3); end
        checks++; if (c2 !== 1'b0) begin errors++; $display("FAIL me_cas_en: got %b want 0", c2); end
        rreg(2, r);
        checks++; if (r !== 8'h02) begin errors++; $display("FAIL me_isr: got %h want 02", r); end
        rreg(1, r);
        checks++; if (r !== 8'h10) begin errors++; $display("FAIL me_irr: got %h want 10", r); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL me_int_nested: got %b want 0", irq); end
        wreg(3, 8'h00);
        rreg(2, r);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL me_isr_eoi: got %h want 00", r); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL me_int_eoi: got %b want 1", irq); end
        ack(d, e1, e2, e3, cs, c1, c2, c3);
        checks++; if ({e2, d} !== 9'h134) begin errors++; $display("FAIL me_vec2: got %b/%h want 1/34", e2, d); end
        ir = 8'h00;
    endtask

    task automatic test_master_cascade();
        logic [7:0] d, r; logic e1, e2, e3, c1, c2, c3; logic [2:0] cs;
        do_reset();
        wreg(0, 8'h00); wreg(4, 8'h10);
        rreg(4, r);
        checks++; if (r !== 8'h10) begin errors++; $display("FAIL mc_map: got %h want 10", r); end
        ir = 8'h10; cyc(3);
        ack(d, e1, e2, e3, cs, c1, c2, c3);
        checks++; if ({c1, cs} !== 4'hC) begin errors++; $display("FAIL mc_cas_p1: got %b/%0d want 1/4", c1, cs); end
        checks++; if (c2 !== 1'b1) begin errors++; $display("FAIL mc_cas_p2: got %b want 1", c2); end
        checks++; if (c3 !== 1'b0) begin errors++; $display("FAIL mc_cas_after: got %b want 0", c3); end
        checks++; if ({e1, e2, e3} !== 3'b000) begin errors++; $display("FAIL mc_dout_en: got %b want 000", {e1, e2, e3}); end
        rreg(2, r);
        checks++; if (r !== 8'h10) begin errors++; $display("FAIL mc_isr: got %h want 10", r); end
        ir = 8'h00;
    endtask

    task automatic test_slave();
        logic [7:0] d, r; logic e1, e2, e3, c1, c2, c3; logic [2:0] cs;
        do_reset();
        sp = 1'b0;
        wreg(5, 8'h04); wreg(2, 8'h30); wreg(0, 8'h00);
        rreg(5, r);
        checks++; if (r !== 8'h04) begin errors++; $display("FAIL sl_id: got %h want 04", r); end
        ir = 8'h12; cyc(3);
        cas_in = 3'd1;
        ack(d, e1, e2, e3, cs, c1, c2, c3);
        checks++; if (e2 !== 1'b0) begin errors++; $display("FAIL sl_miss_den: got %b want 0", e2); end
        rreg(2, r);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL sl_miss_isr: got %h want 00", r); end
        rreg(1, r);
        checks++; if (r !== 8'h12) begin errors++; $display("FAIL sl_miss_irr: got %h want 12", r); end
        cas_in = 3'd4;
        ack(d, e1, e2, e3, cs, c1, c2, c3);
        checks++; if ({e2, d} !== 9'h131) begin errors++; $display("FAIL sl_hit_vec: got %b/%h want 1/31", e2, d); end
        rreg(2, r);
        checks++; if (r !== 8'h02) begin errors++; $display("FAIL sl_hit_isr: got %h want 02", r); end
        rreg(1, r);
        checks++; if (r !== 8'h10) begin errors++; $display("FAIL sl_hit_irr: got %h want 10", r); end
        ir = 8'h00; sp = 1'b1; cas_in = 3'd0;
    endtask

    task automatic test_rot_aeoi();
        logic [7:0] d, r; logic e1, e2, e3, c1, c2, c3; logic [2:0] cs;
        do_reset();
        wreg(1, 8'h06); wreg(2, 8'h40); wreg(0, 8'h00);
        ir = 8'h09; cyc(3);
        ack(d, e1, e2, e3, cs, c1, c2, c3);
        checks++; if ({e2, d} !== 9'h140) begin errors++; $display("FAIL ra_vec0: got %b/%h want 1/40", e2, d); end
        rreg(2, r);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL ra_isr0: got %h want 00", r); end
        checks++; if (dut.r_prio_low !== 3'd0) begin errors++; $display("FAIL ra_prio0: got %0d want 0", dut.r_prio_low); end
        ack(d, e1, e2, e3, cs, c1, c2, c3);
        checks++; if ({e2, d} !== 9'h143) begin errors++; $display("FAIL ra_vec3: got %b/%h want 1/43", e2, d); end
        rreg(2, r);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL ra_isr3: got %h want 00", r); end
        checks++; if (dut.r_prio_low !== 3'd3) begin errors++; $display("FAIL ra_prio3: got %0d want 3", dut.r_prio_low); end
        rreg(1, r);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL ra_irr: got %h want 00", r); end
        ir = 8'h00;
    endtask

    task automatic test_level_spurious();
        logic [7:0] d, r; logic e1, e2, e3, c1, c2, c3; logic [2:0] cs;
        do_reset();
        wreg(1, 8'h01); wreg(2, 8'h50); wreg(0, 8'h00);
        ir = 8'h20; cyc(3);
        rreg(1, r);
        checks++; if (r !== 8'h20) begin errors++; $display("FAIL lv_irr_hi: got %h want 20", r); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL lv_int_hi: got %b want 1", irq); end
        ir = 8'h00; cyc(2);
        rreg(1, r);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL lv_irr_lo: got %h want 00", r); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL lv_int_lo: got %b want 0", irq); end
        ack(d, e1, e2, e3, cs, c1, c2, c3);
        checks++; if ({e2, d} !== 9'h157) begin errors++; $display("FAIL lv_spur_vec: got %b/%h want 1/57", e2, d); end
        rreg(2, r);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL lv_spur_isr: got %h want 00", r); end
    endtask

    task automatic test_mask_reset();
        logic [7:0] d, r; logic e1, e2, e3, c1, c2, c3; logic [2:0] cs;
        do_reset();
        wreg(0, 8'hFF); wreg(2, 8'h60); wreg(4, 8'h02);
        ir = 8'hFF; cyc(3);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mr_int_masked: got %b want 0", irq); end
        rreg(1, r);
        checks++; if (r !== 8'hFF) begin errors++; $display("FAIL mr_irr_capture: got %h want ff", r); end
        wreg(0, 8'h00); cyc(1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mr_int_unmask: got %b want 1", irq); end
        ack(d, e1, e2, e3, cs, c1, c2, c3);
        checks++; if ({e2, d} !== 9'h160) begin errors++; $display("FAIL mr_vec0: got %b/%h want 1/60", e2, d); end
        // second acknowledge up to WAIT2 (level 1 is cascaded), then reset
        @(negedge clk); inta = 1'b0;
        @(negedge clk);
        @(negedge clk); inta = 1'b1;
        @(negedge clk);
        checks++; if ({cas_en, cas_out} !== 4'h9) begin errors++; $display("FAIL mr_cas_pre: got %b/%0d want 1/1", cas_en, cas_out); end
        rst = 1'b1; #1;
        checks++; if ({irq, dout_en, cas_en} !== 3'b000) begin errors++; $display("FAIL mr_rst_en: got %b want 000", {irq, dout_en, cas_en}); end
        checks++; if ({dout, cas_out} !== 11'h000) begin errors++; $display("FAIL mr_rst_data: got %h/%h want 00/0", dout, cas_out); end
        @(negedge clk); rst = 1'b0;
        rreg(0, r);
        checks++; if (r !== 8'hFF) begin errors++; $display("FAIL mr_rst_imr: got %h want ff", r); end
        wreg(0, 8'h00); cyc(1);
        ack(d, e1, e2, e3, cs, c1, c2, c3);
        checks++; if ({e1, e2, d, e3} !== 11'b0_1_00000000_0) begin errors++; $display("FAIL mr_idle_ack: got %b/%b/%h/%b want 0/1/00/0", e1, e2, d, e3); end
        ir = 8'h00;
    endtask

    task automatic test_random();
        logic [7:0] d, r, m_irr, m_isr, m_imr, vb, pulse, exp_d;
        logic e1, e2, e3, c1, c2, c3; logic [2:0] cs;
        logic exp_int;
        int plow, w, pt, it_top, ch, lvl;
        bit rot;
        do_reset();
        rot = 1'($urandom_range(0, 1));
        wreg(1, {5'b0, rot, 2'b00});
        vb = 8'($urandom) & 8'hF8;
        wreg(2, vb);
        m_irr = '0; m_isr = '0; plow = N - 1;
        for (int it = 0; it < 24; it++) begin
            m_imr = 8'($urandom) & 8'($urandom);
            wreg(0, m_imr);
            pulse = 8'($urandom) & 8'($urandom);
            @(negedge clk); ir = pulse;
            @(negedge clk); ir = 8'h00;
            cyc(2);
            m_irr = m_irr | pulse;
            pt = m_top(m_irr & ~m_imr, plow);
            it_top = m_top(m_isr, plow);
            exp_int = (pt >= 0) && ((it_top < 0) || (m_rank(pt, plow) < m_rank(it_top, plow)));
            checks++; if (irq !== exp_int) begin errors++; $display("FAIL rnd_int[%0d]: got %b want %b", it, irq, exp_int); end
            ack(d, e1, e2, e3, cs, c1, c2, c3);
            w = pt;
            if (w < 0) exp_d = vb | 8'(N - 1);
            else begin
                exp_d = vb | 8'(w);
                m_isr[w] = 1'b1;
                m_irr[w] = 1'b0;
            end
            checks++; if ({e2, d} !== {1'b1, exp_d}) begin errors++; $display("FAIL rnd_vec[%0d]: got %b/%h want 1/%h", it, e2, d, exp_d); end
            rreg(2, r);
            checks++; if (r !== m_isr) begin errors++; $display("FAIL rnd_isr[%0d]: got %h want %h", it, r, m_isr); end
            rreg(1, r);
            checks++; if (r !== m_irr) begin errors++; $display("FAIL rnd_irr[%0d]: got %h want %h", it, r, m_irr); end
            ch = $urandom_range(0, 3);
            if (ch == 1 || ch == 2) begin
                wreg(3, 8'h00);
                it_top = m_top(m_isr, plow);
                if (it_top >= 0) begin
                    m_isr[it_top] = 1'b0;
                    if (rot) plow = it_top;
                end
            end else if (ch == 3) begin
                lvl = $urandom_range(0, N - 1);
                wreg(3, 8'h80 | 8'(lvl));
                if (m_isr[lvl]) begin
                    m_isr[lvl] = 1'b0;
                    if (rot) plow = lvl;
                end
            end
            rreg(2, r);
            checks++; if (r !== m_isr) begin errors++; $display("FAIL rnd_isr_eoi[%0d]: got %h want %h", it, r, m_isr); end
            checks++; if (int'(dut.r_prio_low) != plow) begin errors++; $display("FAIL rnd_prio[%0d]: got %0d want %0d", it, dut.r_prio_low, plow); end
        end
    endtask

    initial begin
        test_reset();
        test_master_edge();
        test_master_cascade();
        test_slave();
        test_rot_aeoi();
        test_level_spurious();
        test_mask_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pic_core_n.md
Name: pic_core_n

Overview:
- Clocked, parametrised successor to the combinational 8259-style PIC.
- N_IRQ request lines, with edge- or level-triggered capture and fully-nested or rotating priority.
- Supports auto-EOI and master/slave cascading over a CAS bus.
- Sits between peripheral IR lines and the CPU INTA/data-bus interface. One master can steer up to 2^CAS_W slaves.

Parameters:
N_IRQ, 8, number of request lines (2..8)
CAS_W, 3, cascade ID width
IDX_W, 3, width of a request index; must satisfy 2^IDX_W >= N_IRQ

Ports:
CLK  in  1  system clock, all state on rising edge
RST  in  1  asynchronous, active-high reset
WR  in  1  register write strobe, one cycle
RD  in  1  register read enable
ADDR  in  3  register select
WDATA  in  8  write data
RDATA  out  8  read data, combinational from ADDR when RD=1, else 0
IR  in  N_IRQ  interrupt requests, already synchronous to CLK
INT  out  1  interrupt to CPU, registered
INTA  in  1  acknowledge, active-low, sampled on CLK
SP  in  1  1=master, 0=slave
CAS_IN  in  CAS_W  cascade ID from master (used in slave mode)
CAS_OUT  out  CAS_W  cascade ID driven by master
CAS_OUT_EN  out  1  CAS_OUT valid
DOUT  out  8  vector byte
DOUT_EN  out  1  DOUT valid

Behaviour:
- Register map, writes:
  - 0 IMR[N_IRQ-1:0].
  - 1 CTRL: bit0 LTIM (1=level), bit1 AEOI, bit2 ROT.
  - 2 VBASE: low IDX_W bits forced 0.
  - 3 OCW: bit7=0 non-specific EOI; bit7=1 specific EOI of level WDATA[IDX_W-1:0].
  - 4 SLAVE_MAP (master: IR k has a slave).
  - 5 SLAVE_ID[CAS_W-1:0].
- Register map, reads: 0 IMR, 1 IRR, 2 ISR, 3 VBASE, 4 SLAVE_MAP, 5 SLAVE_ID, 6/7 return 0.
- Reset values:
  - IMR=all 1s; CTRL=0; VBASE=0; SLAVE_MAP=0; SLAVE_ID=0; IRR=0; ISR=0.
  - PRIO_LOW=N_IRQ-1, so IR0 is highest priority.
  - INT=0, DOUT=0, DOUT_EN=0, CAS_OUT=0, CAS_OUT_EN=0, state=IDLE.
  - A reset mid-acknowledge returns to IDLE immediately and deasserts all enables.
- IRR capture:
  - Edge mode: IRR[k] sets on IR[k] 0->1 versus the previous-cycle sample.
  - Level mode: IRR[k] <= IR[k] every cycle.
  - IMR does not block capture.
- Priority:
  - The highest-priority level is (PRIO_LOW+1) mod N_IRQ, descending cyclically from there.
  - ROT=1: each EOI of level k sets PRIO_LOW=k. ROT=0: PRIO_LOW is held at N_IRQ-1.
- INT:
  - Registered. Rises one cycle after some IRR&~IMR bit outranks every ISR bit; any such bit qualifies when ISR=0.
  - Falls one cycle after that condition clears, or at the first INTA falling edge.
- INTA edge detect: falling edge = INTA_d=1 and INTA=0.
- FSM: IDLE -> PULSE1 -> WAIT2 -> PULSE2 -> IDLE.
- IDLE, on falling edge:
  - Latch winner W, the highest-priority IRR&~IMR bit.
  - If there is none, W=N_IRQ-1 and the cycle is marked spurious (no ISR/IRR change).
  - Master, non-spurious: ISR[W]<=1 and, in edge mode, IRR[W]<=0. If SLAVE_MAP[W]=1, CAS_OUT<=W and CAS_OUT_EN<=1.
  - Go to PULSE1.
- PULSE1: on INTA=1 go to WAIT2.
- WAIT2, on falling edge:
  - Master: if SLAVE_MAP[W]=0, DOUT<=VBASE|W and DOUT_EN<=1.
  - Slave: only if CAS_IN==SLAVE_ID (sampled this cycle), commit ISR[W]/IRR[W] as the master does and drive DOUT. On mismatch, make no state change and keep DOUT_EN=0.
  - Go to PULSE2.
- PULSE2, on INTA=1:
  - DOUT_EN<=0 and CAS_OUT_EN<=0.
  - If AEOI and committed, clear ISR[W] and apply the ROT rule.
  - Go to IDLE.
- IMR/CTRL writes during an acknowledge take effect immediately but do not change the latched W.
- EOI:
  - Non-specific clears the highest-priority set ISR bit; with ISR=0 it has no effect.
  - Specific clears ISR[level]; it is a no-op if that bit is clear or level>=N_IRQ.
- Simultaneous events:
  - A new IR edge on the same cycle as the IRR[W] clear: set wins.
  - A register write on the same cycle as an acknowledge commit: the commit's ISR update and the EOI are both applied, commit first.

Test Plan:
- Master, edge, VBASE=0x30, IMR=0, IR=0x12 -> INT=1. Ack1 -> ISR=0x02. Ack2 -> DOUT=0x31, DOUT_EN only during the second INTA low. Non-specific EOI, IR stays 0x12 -> ISR=0, INT=1. Ack -> DOUT=0x34.
- Master, SLAVE_MAP=0x10, IR=0x10 -> CAS_OUT=4, CAS_OUT_EN from first falling edge to second rising edge; DOUT_EN stays 0; ISR=0x10.
- Slave, SLAVE_ID=4, IR=0x12: CAS_IN=1 on ack -> no DOUT_EN, ISR=0, IRR=0x12. CAS_IN=4 -> DOUT=VBASE|1, ISR=0x02.
- ROT=1, AEOI=1, IR edges on 0 and 3 -> vectors for 0 then 3. After each ack, ISR=0 and PRIO_LOW equals the level just acknowledged.
- Level mode, IR[5] high then dropped before ack -> IRR[5]=0; the ack is spurious (DOUT=VBASE|7, ISR unchanged).
- IMR=0xFF with IR=0xFF -> INT=0. RST pulsed during WAIT2 -> all outputs 0, state IDLE, IMR=0xFF.
